mult_arbiter: RTL and testbench

- Round-robin arbiter sharing one sequential multiplier between NUM_REQ requesters.
- Multiplier is 16-bit x 8-bit -> 24-bit, with a start/busy handshake.
- Sits between the function-level controllers (e.g. a^3 + a*b evaluators) and a single mult instance, so several controllers can share one multiplier.
- Sequences the start pulse, waits out busy, then returns the product and a per-requester done pulse.

---
 rtl/mult_arbiter.sv | 153 +++++++++++++++
 tb/tb_mult_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential 16x8 multiplier between NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a watchdog that aborts a job stuck for TIMEOUT_CYCLES.
module mult_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned PTR_W          = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [16*NUM_REQ-1:0] req_a_bi,
  input  logic [8*NUM_REQ-1:0]  req_b_bi,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [23:0]           result_bo,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  mult_start_o,
  output logic [15:0]           mult_a_bo,
  output logic [7:0]            mult_b_bo,
  input  logic                  mult_busy_i,
  input  logic [23:0]           mult_y_bi
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, r_gnt, w_gnt_idx;
  logic               w_gnt_vld;
  logic [PTR_W+1:0]   w_cand;
  logic [15:0]        w_a [NUM_REQ];
  logic [7:0]         w_b [NUM_REQ];
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_abort;

  logic [NUM_REQ-1:0] r_done;
  logic [23:0]        r_result;
  logic               r_start;
  logic [15:0]        r_a;
  logic [7:0]         r_b;

  if (PTR_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("mult_arbiter: inconsistent parameters");
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign w_a[k] = req_a_bi[16*k +: 16];
    assign w_b[k] = req_b_bi[8*k +: 8];
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    // Scan farthest-first so the candidate nearest pointer+1 is the last to win.
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = {2'b00, r_ptr} + (PTR_W+2)'(i);
      if (w_cand >= (PTR_W+2)'(NUM_REQ)) begin
        w_cand = w_cand - (PTR_W+2)'(NUM_REQ);
      end
      if (req_i[w_cand[PTR_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end
    end
  end

  assign w_gnt_oh = NUM_REQ'(1) << r_gnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_gnt_vld)   w_state_nxt = StIssue;
      StIssue: if (mult_busy_i) w_state_nxt = StWait;
      StWait:  if (!mult_busy_i) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_abort) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_done <= '0;
      if (r_state == StIdle && w_gnt_vld) begin
        r_gnt   <= w_gnt_idx;
        r_a     <= w_a[w_gnt_idx];
        r_b     <= w_b[w_gnt_idx];
        r_start <= 1'b1;
      end
      if (r_state == StIssue && mult_busy_i) r_start <= 1'b0;
      if (r_state == StDone) begin
        r_result <= mult_y_bi;
        r_done   <= w_gnt_oh;
        r_ptr    <= r_gnt;
      end
      if (w_abort) begin
        r_start  <= 1'b0;
        r_result <= '0;
        r_done   <= w_gnt_oh;
        r_ptr    <= r_gnt;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_err;

  // Counter sits at zero in IDLE, so it is cleared on entry to ISSUE.
  assign w_abort = (r_state == StIssue || r_state == StWait) &&
                   (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state == StIdle || w_abort) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign err_o = r_err;
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign done_o       = r_done;
  assign result_bo    = r_result;
  assign busy_o       = (r_state != StIdle);
  assign mult_start_o = r_start;
  assign mult_a_bo    = r_a;
  assign mult_b_bo    = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: job-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int N = 2;
  localparam int T = 16;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] req_a = '0;
  logic [8*N-1:0]  req_b = '0;
  logic [N-1:0]    d_done;
  logic [23:0]     d_result;
  logic            d_err, d_busy, d_start;
  logic [15:0]     d_a;
  logic [7:0]      d_b;
  logic            m_busy_in = 1'b0;
  logic [23:0]     m_y_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_arbiter #(
    .NUM_REQ       (N),
    .PTR_W         (1),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req),
    .req_a_bi    (req_a),
    .req_b_bi    (req_b),
    .done_o      (d_done),
    .result_bo   (d_result),
    .err_o       (d_err),
    .busy_o      (d_busy),
    .mult_start_o(d_start),
    .mult_a_bo   (d_a),
    .mult_b_bo   (d_b),
    .mult_busy_i (m_busy_in),
    .mult_y_bi   (m_y_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench knobs for the multiplier model, read when a job is granted.
  int dly_sel = 1;
  int len_sel = 8;
  bit never_mode = 0;
  bit rand_mode = 0;

  // Inputs as the DUT saw them on the last rising edge.
  logic [N-1:0]    req_s;
  logic [16*N-1:0] a_s;
  logic [8*N-1:0]  b_s;

  initial forever begin
    @(posedge clk);
    req_s = req;
    a_s   = req_a;
    b_s   = req_b;
  end

  // Job-level reference: one job in flight, timeline computed in closed form at grant.
  int          k, g, st_end, e, idx, ptr, cur_dly, cur_len;
  bit          act, tmo_job;
  logic [23:0] exp_res, job_prod;
  logic [15:0] exp_a;
  logic [7:0]  exp_b;
  logic [N-1:0] exp_done;
  logic        exp_err;
  // Multiplier model state.
  bit          m_busy;
  int          m_rem, m_scnt;
  logic [23:0] m_prod;
  logic        st_prev;
  logic [15:0] a_prev;
  logic [7:0]  b_prev;

  task automatic model_reset();
    k = 0; act = 0; ptr = 0; idx = 0; tmo_job = 0;
    exp_res = '0; exp_a = '0; exp_b = '0;
    m_busy = 0; m_rem = 0; m_scnt = 0; m_prod = '0;
    st_prev = 0; a_prev = '0; b_prev = '0;
    m_busy_in = 1'b0; m_y_in = '0;
  endtask

  task automatic model_step();
    bit found;
    int c;
    k++;
    // Multiplier: reacts to what the DUT presented before this edge.
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) m_busy = 0;
    end else if (st_prev) begin
      m_scnt++;
      if (m_scnt == cur_dly) begin
        m_busy = 1; m_rem = cur_len; m_scnt = 0;
        m_prod = 24'(a_prev) * 24'(b_prev);
      end
    end else begin
      m_scnt = 0;
    end
    m_busy_in = m_busy;
    m_y_in    = m_busy ? 24'hA5A5A5 : m_prod;

    exp_done = '0;
    exp_err  = 1'b0;
    if (act && k == e) begin
      exp_done[idx] = 1'b1;
      exp_err = tmo_job;
      exp_res = tmo_job ? 24'h0 : job_prod;
      ptr = idx;
      act = 0;
    end else if (!act && req_s != '0) begin
      found = 0;
      for (int j = 1; j <= N; j++) begin
        c = (ptr + j) % N;
        if (!found && req_s[c]) begin found = 1; idx = c; end
      end
      act = 1; g = k;
      exp_a = a_s[16*idx +: 16];
      exp_b = b_s[8*idx +: 8];
      job_prod = 24'(exp_a) * 24'(exp_b);
      cur_dly = never_mode ? 1000000 : (rand_mode ? int'($urandom_range(1, 3)) : dly_sel);
      cur_len = rand_mode ? int'($urandom_range(1, 10)) : len_sel;
      if (TmoEn && T <= cur_dly + cur_len + 1) begin
        tmo_job = 1; e = g + T; st_end = g + T - 1;
      end else begin
        tmo_job = 0; e = g + cur_dly + cur_len + 2; st_end = g + cur_dly;
      end
    end

    chk("busy_o", d_busy, act);
    chk("mult_start_o", d_start, act && k <= st_end);
    chk("done_o", d_done, exp_done);
    chk("err_o", d_err, exp_err);
    chk("result_bo", d_result, exp_res);
    chk("mult_a_bo", d_a, exp_a);
    chk("mult_b_bo", d_b, exp_b);
    chk("done_onehot", $countones(d_done) <= 1, 1);

    st_prev = d_start;
    a_prev  = d_a;
    b_prev  = d_b;
  endtask

  initial begin : scoreboard
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_ni) model_reset();
      else model_step();
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_done_o"}, d_done, 0);
    chk({name, "_result_bo"}, d_result, 0);
    chk({name, "_err_o"}, d_err, 0);
    chk({name, "_busy_o"}, d_busy, 0);
    chk({name, "_mult_start_o"}, d_start, 0);
    chk({name, "_mult_a_bo"}, d_a, 0);
    chk({name, "_mult_b_bo"}, d_b, 0);
  endtask

  // Waits for a done pulse; lat counts falling edges from the call, starts counts start-high cycles.
  task automatic wait_done(input int maxc, input bit drop, output int di, output int lat,
                           output int starts);
    bit seen = 0;
    di = -1; lat = 0; starts = 0;
    while (!seen && lat < maxc) begin
      @(negedge clk);
      lat++;
      if (d_start) starts++;
      if (d_done != '0) begin
        seen = 1;
        for (int i = 0; i < N; i++) if (d_done[i]) di = i;
        if (drop) req = req & ~d_done;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_done: no done_o within %0d cycles", maxc);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "time limit");
  end

  initial begin : main
    int di, lat, st, seen;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    #1 rst_ni = 1'b1;

    // Single request: 0xFF * 0xFF, busy 8 cycles -> done 12 falling edges after req rises.
    req_a[15:0] = 16'h00FF; req_b[7:0] = 8'hFF; req = 2'b01;
    wait_done(40, 1, di, lat, st);
    chk("single_idx", di, 0);
    chk("single_latency", lat, 12);
    chk("single_result", d_result, 24'h00FE01);

    // Zero operand, then the largest operands.
    @(negedge clk);
    req_a[15:0] = 16'h0000; req_b[7:0] = 8'h80; req = 2'b01;
    wait_done(40, 1, di, lat, st);
    chk("zero_result", d_result, 24'h000000);
    chk("zero_idx", di, 0);
    @(negedge clk);
    req_a[15:0] = 16'hFFFF; req_b[7:0] = 8'hFF; req = 2'b01;
    wait_done(40, 1, di, lat, st);
    chk("max_result", d_result, 24'hFEFF01);
    chk("max_latency", lat, 12);

    // Slow start handshake: busy rises two edges after start is first seen -> start up 3 cycles.
    @(negedge clk);
    dly_sel = 2;
    req_a[15:0] = 16'h1234; req_b[7:0] = 8'h56; req = 2'b01;
    wait_done(40, 1, di, lat, st);
    chk("hs_start_cycles", st, 3);
    chk("hs_latency", lat, 13);
    chk("hs_result", d_result, 24'h061D78);
    dly_sel = 1;

    // Contention, both requests held from reset: grants 1,0,1,0.
    @(negedge clk);
    #1 rst_ni = 1'b0;
    req_a = {16'd300, 16'd3}; req_b = {8'd200, 8'd5}; req = 2'b11;
    @(negedge clk);
    #1 rst_ni = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_done(40, 0, di, lat, st);
      chk($sformatf("cont_idx%0d", n), di, (n % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_res%0d", n), d_result, (n % 2 == 0) ? 24'd60000 : 24'd15);
    end
    req = '0;

    // Asynchronous reset while the job sits in WAIT.
    repeat (2) @(negedge clk);
    req_a[15:0] = 16'h0101; req_b[7:0] = 8'h02; req = 2'b01;
    repeat (6) @(negedge clk);
    chk("async_pre_busy", d_busy, 1);
    #2 rst_ni = 1'b0;
    req = '0;
    #1 chk_zero("async");
    @(negedge clk);
    @(negedge clk);
    #1 rst_ni = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_done != '0) seen++;
    end
    chk("async_no_done", seen, 0);
    req_a[31:16] = 16'd300; req_b[15:8] = 8'd200; req = 2'b10;
    wait_done(40, 1, di, lat, st);
    chk("async_after_idx", di, 1);
    chk("async_after_result", d_result, 24'd60000);

`ifdef MULT_ARB_TIMEOUT_EN
    // Multiplier never answers: abort after T cycles, then a normal job.
    @(negedge clk);
    never_mode = 1;
    req_a[15:0] = 16'd5; req_b[7:0] = 8'd7; req = 2'b01;
    wait_done(60, 1, di, lat, st);
    chk("tmo_err", d_err, 1);
    chk("tmo_idx", di, 0);
    chk("tmo_latency", lat, T + 1);
    chk("tmo_result", d_result, 0);
    never_mode = 0;
    @(negedge clk);
    req_a[31:16] = 16'd2; req_b[15:8] = 8'd3; req = 2'b10;
    wait_done(40, 1, di, lat, st);
    chk("tmo_next_result", d_result, 24'd6);
    chk("tmo_next_err", d_err, 0);
`endif

    // Random traffic with random multiplier timing, checked by the scoreboard.
    @(negedge clk);
    rand_mode = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (d_done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[8*i +: 8]   = 8'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (30) @(negedge clk);
    rand_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
